// File: rtl/vector_demux_pkg.sv
// Shared definitions for the element-serial float path (deserializer/serializer).
package vector_demux_pkg;

  localparam int FP_WIDTH = 32;

  typedef enum logic {FILL, FULL} state_t;

  // Slot-index width: max(1, clog2(n)).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vector_demux_if.sv
// Element-in / vector-out handshake bundle for vector_demux.
interface vector_demux_if
  import vector_demux_pkg::*;
#(
  parameter int VLEN = 4
);
  localparam int IDX_W = idx_w(VLEN);

  logic                     in_valid;
  logic                     in_ready;
  logic [FP_WIDTH-1:0]      num;
  logic [FP_WIDTH*VLEN-1:0] vec;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W:0]           fill_cnt;

  modport master (output in_valid, num, out_ready,
                  input  in_ready, vec, out_valid, fill_cnt);
  modport slave  (input  in_valid, num, out_ready,
                  output in_ready, vec, out_valid, fill_cnt);
endinterface

// File: rtl/vector_demux.sv
// Collects serial 32-bit float words into a VLEN-element vector register.
// Optional VECTOR_DEMUX_PASSTHRU_EN: accept slot 0 in the same cycle as the handoff.
module vector_demux
  import vector_demux_pkg::*;
#(
  parameter int VLEN = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  vector_demux_if.slave  bus
);
  localparam int                IDX_W    = idx_w(VLEN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(VLEN - 1);
  localparam logic [IDX_W:0]    FULL_CNT = (IDX_W + 1)'(VLEN);

  state_t                           r_state;
  logic [IDX_W-1:0]                 r_idx;
  logic [IDX_W:0]                   r_fill;
  logic [VLEN-1:0][FP_WIDTH-1:0]    r_vec;
  logic                             w_in_ready;
  logic                             w_accept;

`ifdef VECTOR_DEMUX_PASSTHRU_EN
  assign w_in_ready = rst_n & ((r_state == FILL) | ((r_state == FULL) & bus.out_ready));
`else
  assign w_in_ready = rst_n & (r_state == FILL);
`endif
  assign w_accept = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_idx   <= '0;
      r_fill  <= '0;
      r_vec   <= '0;
    end else if (clear) begin
      // Abort drops any partial/held vector but leaves vec contents in place.
      r_state <= FILL;
      r_idx   <= '0;
      r_fill  <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_vec[r_idx] <= bus.num;
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_fill  <= FULL_CNT;
              r_state <= FULL;
            end else begin
              r_idx  <= r_idx + 1'b1;
              r_fill <= r_fill + 1'b1;
            end
          end
        end
        FULL: begin
          if (bus.out_ready) begin
`ifdef VECTOR_DEMUX_PASSTHRU_EN
            if (w_accept) begin
              r_vec[0] <= bus.num;
              if (VLEN == 1) begin
                r_fill <= FULL_CNT;
              end else begin
                r_idx   <= IDX_W'(1);
                r_fill  <= (IDX_W + 1)'(1);
                r_state <= FILL;
              end
            end else
`endif
            begin
              r_fill  <= '0;
              r_state <= FILL;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == FULL);
  assign bus.vec       = r_vec;
  assign bus.fill_cnt  = r_fill;

endmodule

// File: tb/tb_vector_demux.sv
// Self-checking bench for vector_demux (VLEN=4 and VLEN=1 instances).
module tb_vector_demux;
  import vector_demux_pkg::*;

  localparam int VL = 4;
`ifdef VECTOR_DEMUX_PASSTHRU_EN
  localparam bit PT     = 1'b1;
  localparam int PERIOD = 4;
`else
  localparam bit PT     = 1'b0;
  localparam int PERIOD = 5;
`endif

  logic clk = 1'b0, rst_n = 1'b1, clr4 = 1'b0, clr1 = 1'b0;
  always #5 clk = ~clk;

  vector_demux_if #(.VLEN(4)) if4();
  vector_demux_if #(.VLEN(1)) if1();

  vector_demux #(.VLEN(4)) dut4 (.clk(clk), .rst_n(rst_n), .clear(clr4), .bus(if4));
  vector_demux #(.VLEN(1)) dut1 (.clk(clk), .rst_n(rst_n), .clear(clr1), .bus(if1));

  int nchk = 0, nerr = 0;

  // Reference model: a queue of accepted words plus a held vector.
  logic [31:0] m_q[$];
  logic [31:0] m_hvec[VL];
  bit          m_held = 1'b0;
  bit          m_acc  = 1'b0;

  typedef struct {
    bit           iv;
    logic [31:0]  n;
    bit           ordy;
    bit           clr;
    bit           eov;
    int           efc;
    bit           cv;
    logic [127:0] ev;
  } row_t;
  row_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mvec();
    logic [127:0] r;
    for (int k = 0; k < VL; k++) r[32*k +: 32] = m_hvec[k];
    return r;
  endfunction

  // One clock of the VLEN=4 instance, checked against the model.
  task automatic cyc(input bit iv, input logic [31:0] n, input bit ordy, input bit clr);
    if4.in_valid  = iv;
    if4.num       = n;
    if4.out_ready = ordy;
    clr4          = clr;
    #1;
    chk("in_ready", {127'd0, if4.in_ready}, {127'd0, (!m_held || (PT && ordy))});
    @(posedge clk);
    m_acc = iv && (!m_held || (PT && ordy));
    if (clr) begin
      m_q.delete();
      m_held = 1'b0;
      m_acc  = 1'b0;
    end else begin
      if (m_held && ordy) m_held = 1'b0;
      if (m_acc) begin
        m_q.push_back(n);
        if (m_q.size() == VL) begin
          for (int k = 0; k < VL; k++) m_hvec[k] = m_q[k];
          m_q.delete();
          m_held = 1'b1;
        end
      end
    end
    #1;
    chk("out_valid", {127'd0, if4.out_valid}, {127'd0, m_held});
    chk("fill_cnt", {125'd0, if4.fill_cnt}, 128'(m_held ? VL : m_q.size()));
    if (m_held) chk("vec", if4.vec, mvec());
  endtask

  function automatic row_t mk(bit iv, logic [31:0] n, bit ordy, bit eov, int efc,
                              bit cv, logic [127:0] ev);
    row_t r;
    r.iv = iv; r.n = n; r.ordy = ordy; r.clr = 1'b0;
    r.eov = eov; r.efc = efc; r.cv = cv; r.ev = ev;
    return r;
  endfunction

  initial begin
    int          acc_cnt;
    int          word;
    int          times[$];
    logic [31:0] cur;

    // Straight fill with out_ready high, then a gapped fill under backpressure.
    tbl.push_back(mk(1, 32'h3F800000, 1, 0, 1, 0, '0));
    tbl.push_back(mk(1, 32'h40000000, 1, 0, 2, 0, '0));
    tbl.push_back(mk(1, 32'h40400000, 1, 0, 3, 0, '0));
    tbl.push_back(mk(1, 32'h40800000, 1, 1, 4, 1, 128'h40800000_40400000_40000000_3F800000));
    tbl.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 0, 0, '0));
    tbl.push_back(mk(1, 32'h3F000000, 0, 0, 1, 0, '0));
    tbl.push_back(mk(0, 32'hFFFFFFFF, 0, 0, 1, 0, '0));
    tbl.push_back(mk(0, 32'hFFFFFFFF, 0, 0, 1, 0, '0));
    tbl.push_back(mk(1, 32'hBF000000, 0, 0, 2, 0, '0));
    tbl.push_back(mk(0, 32'hFFFFFFFF, 0, 0, 2, 0, '0));
    tbl.push_back(mk(1, 32'h41200000, 0, 0, 3, 0, '0));
    tbl.push_back(mk(1, 32'hC1200000, 0, 1, 4, 1, 128'hC1200000_41200000_BF000000_3F000000));
    tbl.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 0, 0, '0));

    if4.in_valid = 0; if4.num = '0; if4.out_ready = 0;
    if1.in_valid = 0; if1.num = '0; if1.out_ready = 0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready4", {127'd0, if4.in_ready}, 128'd0);
    chk("rst_in_ready1", {127'd0, if1.in_ready}, 128'd0);
    chk("rst_out_valid", {127'd0, if4.out_valid}, 128'd0);
    chk("rst_fill_cnt", {125'd0, if4.fill_cnt}, 128'd0);
    chk("rst_vec", if4.vec, 128'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].iv, tbl[i].n, tbl[i].ordy, tbl[i].clr);
      chk($sformatf("tbl%0d_ov", i), {127'd0, if4.out_valid}, {127'd0, tbl[i].eov});
      chk($sformatf("tbl%0d_fc", i), {125'd0, if4.fill_cnt}, 128'(tbl[i].efc));
      if (tbl[i].cv) chk($sformatf("tbl%0d_vec", i), if4.vec, tbl[i].ev);
    end

    // Backpressure: held vector stays put while a word waits on in_valid.
    cyc(1, 32'h00000011, 0, 0); cyc(1, 32'h00000022, 0, 0);
    cyc(1, 32'h00000033, 0, 0); cyc(1, 32'h00000044, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'hDEAD0001, 0, 0);
      chk("bp_hold_vec", if4.vec, 128'h00000044_00000033_00000022_00000011);
      chk("bp_hold_ov", {127'd0, if4.out_valid}, 128'd1);
    end
    acc_cnt = 0;
    cur = 32'hDEAD0001;
    for (int i = 0; i < 12 && acc_cnt < VL; i++) begin
      cyc(1, cur, 1, 0);
      if (m_acc) begin acc_cnt++; cur = cur + 1; end
    end
    chk("bp_accepts", 128'(acc_cnt), 128'(VL));
    chk("bp_next_vec", if4.vec, 128'hDEAD0004_DEAD0003_DEAD0002_DEAD0001);
    cyc(0, '0, 1, 0);

    // Clear after two words drops them and the word presented with clear.
    cyc(1, 32'h3F800000, 0, 0); cyc(1, 32'h40000000, 0, 0);
    cyc(1, 32'hDEADBEEF, 0, 1);
    chk("clr_fc", {125'd0, if4.fill_cnt}, 128'd0);
    cyc(1, 32'hA0000001, 0, 0); cyc(1, 32'hA0000002, 0, 0);
    cyc(1, 32'hA0000003, 0, 0); cyc(1, 32'hA0000004, 0, 0);
    chk("clr_vec", if4.vec, 128'hA0000004_A0000003_A0000002_A0000001);
    cyc(1, 32'hDEADBEEF, 1, 1);
    chk("clr_full_ov", {127'd0, if4.out_valid}, 128'd0);
    chk("clr_full_fc", {125'd0, if4.fill_cnt}, 128'd0);

    // VLEN=1: each accept is a full vector.
    if1.in_valid = 1; if1.num = 32'hBF800000; if1.out_ready = 0;
    cyc(0, '0, 0, 0);
    chk("v1_ov", {127'd0, if1.out_valid}, 128'd1);
    chk("v1_vec", {96'd0, if1.vec}, 128'h0BF800000);
    chk("v1_fc", {126'd0, if1.fill_cnt}, 128'd1);
    if1.in_valid = 0; if1.out_ready = 1;
    cyc(0, '0, 0, 0);
    chk("v1_handoff_ov", {127'd0, if1.out_valid}, 128'd0);
    chk("v1_handoff_fc", {126'd0, if1.fill_cnt}, 128'd0);
    if1.out_ready = 0;

    // Asynchronous reset between edges, mid-fill.
    cyc(1, 32'h12345678, 0, 0); cyc(1, 32'h9ABCDEF0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ov", {127'd0, if4.out_valid}, 128'd0);
    chk("arst_fc", {125'd0, if4.fill_cnt}, 128'd0);
    chk("arst_vec", if4.vec, 128'd0);
    chk("arst_in_ready", {127'd0, if4.in_ready}, 128'd0);
    #1 rst_n = 1'b1;
    m_q.delete(); m_held = 1'b0;
    cyc(1, 32'hB0000001, 0, 0); cyc(1, 32'hB0000002, 0, 0);
    cyc(1, 32'hB0000003, 0, 0); cyc(1, 32'hB0000004, 0, 0);
    chk("arst_next_vec", if4.vec, 128'hB0000004_B0000003_B0000002_B0000001);
    cyc(0, '0, 1, 0);

    // Throughput under continuous traffic.
    word = 1;
    for (int c = 0; c < 20; c++) begin
      cyc(1, 32'(word), 1, 0);
      if (m_acc) word++;
      if (if4.out_valid) times.push_back(c);
    end
    chk("tput_vectors", 128'(times.size() >= 3), 128'd1);
    if (times.size() >= 3) begin
      chk("tput_gap1", 128'(times[1] - times[0]), 128'(PERIOD));
      chk("tput_gap2", 128'(times[2] - times[1]), 128'(PERIOD));
    end
    cyc(0, '0, 1, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 40) == 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
